// File: rtl/hvsp_pkg.sv
// Shared definitions for the HVSP operation sequencer: op codes, FSM states and the frame step table.
// Pure declarations; no timing or flow control of its own.
package hvsp_pkg;

  localparam logic [2:0] OP_READ_SIG      = 3'd0;
  localparam logic [2:0] OP_READ_FUSE_LO  = 3'd1;
  localparam logic [2:0] OP_WRITE_FUSE_LO = 3'd2;
  localparam logic [2:0] OP_CHIP_ERASE    = 3'd3;

  localparam int STEP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT1,
    ST_WAIT,
    ST_POLL,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SEL_CONST,
    SEL_ADDR,
    SEL_WDATA
  } sdi_sel_t;

  typedef struct packed {
    logic [7:0] sdi;
    logic [7:0] sii;
    sdi_sel_t   sdi_sel;
    logic       last;
    logic       poll;
  } step_t;

  // Unused slots are marked last so a stray index can never walk off the end of an op.
  localparam step_t STEP_NONE = '{8'h00, 8'h00, SEL_CONST, 1'b1, 1'b0};

  localparam step_t STEP_TABLE [0:15] = '{
    '{8'h08, 8'h4C, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h0C, SEL_ADDR,  1'b0, 1'b0},
    '{8'h00, 8'h68, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h6C, SEL_CONST, 1'b1, 1'b0},
    '{8'h04, 8'h4C, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h68, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h6C, SEL_CONST, 1'b1, 1'b0},
    STEP_NONE,
    '{8'h40, 8'h4C, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h2C, SEL_WDATA, 1'b0, 1'b0},
    '{8'h00, 8'h64, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h6C, SEL_CONST, 1'b1, 1'b1},
    '{8'h80, 8'h4C, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h64, SEL_CONST, 1'b0, 1'b0},
    '{8'h00, 8'h6C, SEL_CONST, 1'b1, 1'b1},
    STEP_NONE
  };

  function automatic logic is_valid_op(input logic [2:0] code);
    return code <= OP_CHIP_ERASE;
  endfunction

endpackage

// File: rtl/hvsp_step_rom.sv
// Combinational lookup of one instruction frame (SDI/SII payload and flags) for a given op and step.
// Zero latency; no flow control.
module hvsp_step_rom
  import hvsp_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [STEP_W-1:0] step,
  input  logic [7:0]        addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        sdi,
  output logic [7:0]        sii,
  output logic              last,
  output logic              poll
);

  step_t entry;

  assign entry = STEP_TABLE[{op, step}];
  assign sii   = entry.sii;
  assign last  = entry.last;
  assign poll  = entry.poll;

  always_comb begin
    sdi = entry.sdi;
    case (entry.sdi_sel)
      SEL_ADDR:  sdi = addr;
      SEL_WDATA: sdi = wdata;
      default:   sdi = entry.sdi;
    endcase
  end

endmodule

// File: rtl/hvsp_op_sequencer.sv
// Runs one HVSP operation as a sequence of shift-engine frames, then optionally polls SDO for ready.
// Busy from the cycle after an accepted start until op_done; starts while busy are dropped.
module hvsp_op_sequencer
  import hvsp_pkg::*;
#(
  parameter int POLL_TIMEOUT = 2400000
) (
  input  logic        osc,
  input  logic        rst,
  input  logic        op_start,
  input  logic [2:0]  op_code,
  input  logic [7:0]  op_addr,
  input  logic [7:0]  op_wdata,
  output logic        op_busy,
  output logic        op_done,
  output logic        op_error,
  output logic [7:0]  op_rdata,
  output logic        frame_start,
  output logic [7:0]  frame_sdi,
  output logic [7:0]  frame_sii,
  input  logic        frame_busy,
  input  logic [10:0] frame_sdo,
  input  logic        sdo_pin
);

  localparam int CW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        code_q;
  logic [STEP_W-1:0] step_q;
  logic [7:0]        addr_q, wdata_q;
  logic              last_q, poll_q;
  logic [CW-1:0]     cnt;
  logic [1:0]        sdo_sync;
  logic              sdo_ready, timeout, accept, op_valid, frame_fall;

  logic [1:0]        rom_op;
  logic [STEP_W-1:0] rom_step;
  logic [7:0]        rom_addr, rom_wdata, rom_sdi, rom_sii;
  logic              rom_last, rom_poll;
  logic              unused_sdo_bits;

  assign accept          = (state == ST_IDLE) && op_start;
  assign op_valid        = is_valid_op(op_code);
  assign frame_fall      = (state == ST_WAIT) && !frame_busy;
  assign sdo_ready       = sdo_sync[1];
  assign timeout         = (cnt == CNT_LAST);
  assign unused_sdo_bits = ^frame_sdo[2:0];

  // The ROM looks one step ahead: the new op's first frame while idle, the following frame otherwise.
  always_comb begin
    if (state == ST_IDLE) begin
      rom_op    = op_code[1:0];
      rom_step  = '0;
      rom_addr  = op_addr;
      rom_wdata = op_wdata;
    end else begin
      rom_op    = code_q;
      rom_step  = step_q + STEP_W'(1);
      rom_addr  = addr_q;
      rom_wdata = wdata_q;
    end
  end

  hvsp_step_rom u_step_rom (
    .op    (rom_op),
    .step  (rom_step),
    .addr  (rom_addr),
    .wdata (rom_wdata),
    .sdi   (rom_sdi),
    .sii   (rom_sii),
    .last  (rom_last),
    .poll  (rom_poll)
  );

  always_ff @(posedge osc) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (op_start) state_nxt = op_valid ? ST_ISSUE : ST_FINISH;
      ST_ISSUE:  state_nxt = ST_WAIT1;
      ST_WAIT1:  state_nxt = ST_WAIT;
      ST_WAIT:   if (!frame_busy) state_nxt = !last_q ? ST_ISSUE : (poll_q ? ST_POLL : ST_FINISH);
      ST_POLL:   if (sdo_ready || timeout) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op_busy     = (state != ST_IDLE);
    frame_start = (state == ST_ISSUE);
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      code_q    <= '0;
      step_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      poll_q    <= 1'b0;
      cnt       <= '0;
      sdo_sync  <= '0;
      op_done   <= 1'b0;
      op_error  <= 1'b0;
      op_rdata  <= '0;
      frame_sdi <= '0;
      frame_sii <= '0;
    end else begin
      sdo_sync <= {sdo_sync[0], sdo_pin};
      op_done  <= (state == ST_FINISH);
      if (accept) begin
        if (op_valid) begin
          code_q    <= op_code[1:0];
          addr_q    <= op_addr;
          wdata_q   <= op_wdata;
          step_q    <= '0;
          op_error  <= 1'b0;
          op_rdata  <= '0;
          frame_sdi <= rom_sdi;
          frame_sii <= rom_sii;
          last_q    <= rom_last;
          poll_q    <= rom_poll;
        end else begin
          op_error <= 1'b1;
        end
      end
      if (frame_fall) begin
        if (!last_q) begin
          step_q    <= rom_step;
          frame_sdi <= rom_sdi;
          frame_sii <= rom_sii;
          last_q    <= rom_last;
          poll_q    <= rom_poll;
        end else if (poll_q) begin
          cnt <= '0;
        end else begin
          op_rdata <= frame_sdo[10:3];
        end
      end
      if (state == ST_POLL && !sdo_ready) begin
        if (timeout)              op_error <= 1'b1;
        else if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
